mio_arbiter: RTL and testbench



---
 rtl/mio_pkg.sv | 30 +++
 rtl/mio_rr_pick.sv | 22 ++
 rtl/mio_arbiter.sv | 135 +++++++++++++
 tb/tb_mio_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mio_pkg.sv
// Shared definitions for the memory/IO bus slice: arbiter FSM state, master
// index type, debug view of the arbiter, and the bus address map.
package mio_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN0 = 2'd1,
    ARB_OWN1 = 2'd2
  } arb_state_e;

  typedef logic mio_idx_t;

  localparam logic [31:0] MIO_RAM_BASE    = 32'h0000_0000;
  localparam logic [31:0] MIO_VRAM_BASE   = 32'h0000_0800;
  localparam logic [31:0] MIO_CURSOR_BASE = 32'h0000_1000;

  localparam int unsigned HOLD_W = 4;

  typedef struct packed {
    arb_state_e       state;
    logic             ack_cyc;
    logic [HOLD_W-1:0] hold_cnt;
    mio_idx_t         last_owner;
  } arb_dbg_t;

  function automatic arb_state_e own_state(mio_idx_t idx);
    return idx ? ARB_OWN1 : ARB_OWN0;
  endfunction

endpackage

// File: rtl/mio_rr_pick.sv
// Two-way round-robin selector: a lone requester wins; on a tie the master
// that did not own the bus last wins.
module mio_rr_pick
  import mio_pkg::*;
(
  input  logic [1:0] req,
  input  mio_idx_t   last_owner,
  output mio_idx_t   grant_idx,
  output logic       grant_valid
);

  always_comb begin
    grant_valid = |req;
    case (req)
      2'b01:   grant_idx = 1'b0;
      2'b10:   grant_idx = 1'b1;
      2'b11:   grant_idx = ~last_owner;
      default: grant_idx = last_owner;
    endcase
  end

endmodule

// File: rtl/mio_arbiter.sv
// Two-master arbiter in front of mio_bus: one transaction at a time, each
// taking an access cycle (strobe) followed by an ack cycle (no strobe).
module mio_arbiter
  import mio_pkg::*;
#(
  parameter int MAX_HOLD = 4,
  parameter int AW       = 32,
  parameter int DW       = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_ack,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_ack,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] d_t_mem,
  input  logic [DW-1:0] d_f_mem,
  output logic          wmem,
  output logic          rmem,
  output logic          owner,
  output logic          busy,
  output arb_dbg_t      dbg
);

  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

  arb_state_e        state;
  logic              ack_cyc;
  logic [HOLD_W-1:0] hold_cnt;
  mio_idx_t          last_owner;
  mio_idx_t          owner_q;

  mio_idx_t grant_idx;
  logic     grant_valid;
  logic     cur;
  logic     cur_we;
  logic     cur_req;
  logic     oth_req;
  logic     access;

  // Handshake: a master raises req with stable addr/we/wdata and keeps it
  // until its one-cycle ack; during the ack cycle it may present the next
  // transaction with req still high.
  assign cur     = (state == ARB_OWN1);
  assign busy    = (state != ARB_IDLE);
  assign access  = busy && !ack_cyc;
  assign cur_we  = cur ? m1_we : m0_we;
  assign cur_req = cur ? m1_req : m0_req;
  assign oth_req = cur ? m0_req : m1_req;
  assign wmem    = access && cur_we;
  assign rmem    = access && !cur_we;
  assign owner   = owner_q;

  always_comb begin
    mem_a   = '0;
    d_t_mem = '0;
    if (busy) begin
      mem_a   = cur ? m1_addr : m0_addr;
      d_t_mem = cur ? m1_wdata : m0_wdata;
    end
  end

  assign dbg = '{state: state, ack_cyc: ack_cyc, hold_cnt: hold_cnt,
                 last_owner: last_owner};

  mio_rr_pick u_pick (
    .req        ({m1_req, m0_req}),
    .last_owner (last_owner),
    .grant_idx  (grant_idx),
    .grant_valid(grant_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ARB_IDLE;
      ack_cyc    <= 1'b0;
      hold_cnt   <= '0;
      last_owner <= 1'b1;
      owner_q    <= 1'b0;
      m0_ack     <= 1'b0;
      m1_ack     <= 1'b0;
      m0_rdata   <= '0;
      m1_rdata   <= '0;
    end else begin
      m0_ack <= access && !cur;
      m1_ack <= access && cur;
      if (access && !cur_we) begin
        if (cur) m1_rdata <= d_f_mem;
        else     m0_rdata <= d_f_mem;
      end
      case (state)
        ARB_IDLE: begin
          if (grant_valid) begin
            state      <= own_state(grant_idx);
            owner_q    <= grant_idx;
            last_owner <= grant_idx;
            hold_cnt   <= HOLD_W'(1);
            ack_cyc    <= 1'b0;
          end
        end
        default: begin
          if (!ack_cyc) begin
            ack_cyc <= 1'b1;
          end else begin
            ack_cyc <= 1'b0;
            // last_owner equals the current owner here, so the picker
            // offers the other master whenever it is requesting.
            if (cur_req && oth_req && (hold_cnt < HOLD_MAX)) begin
              hold_cnt <= hold_cnt + HOLD_W'(1);
            end else if (grant_valid && (grant_idx == cur)) begin
              if (hold_cnt < HOLD_MAX) hold_cnt <= hold_cnt + HOLD_W'(1);
            end else if (grant_valid) begin
              state      <= own_state(grant_idx);
              owner_q    <= grant_idx;
              last_owner <= grant_idx;
              hold_cnt   <= HOLD_W'(1);
            end else begin
              state <= ARB_IDLE;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mio_arbiter.sv
// Bench for mio_arbiter: directed vector table, multi-cycle corner sequences,
// and a randomized run against a transaction-level reference model.
module tb_mio_arbiter;
  import mio_pkg::*;

  localparam int MAX_HOLD = 4;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          m0_req, m0_we, m0_ack;
  logic [31:0]   m0_addr, m0_wdata, m0_rdata;
  logic          m1_req, m1_we, m1_ack;
  logic [31:0]   m1_addr, m1_wdata, m1_rdata;
  logic [31:0]   mem_a, d_t_mem, d_f_mem;
  logic          wmem, rmem, owner, busy;
  arb_dbg_t      dbg;

  int n_checks = 0;
  int n_errors = 0;

  mio_arbiter #(.MAX_HOLD(MAX_HOLD), .AW(32), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdata(m0_rdata), .m0_ack(m0_ack),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rdata(m1_rdata), .m1_ack(m1_ack),
    .mem_a(mem_a), .d_t_mem(d_t_mem), .d_f_mem(d_f_mem),
    .wmem(wmem), .rmem(rmem), .owner(owner), .busy(busy), .dbg(dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst_n  = 1'b0;
    m0_req = 1'b0; m1_req = 1'b0;
    m0_we  = 1'b0; m1_we  = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct packed {
    logic [3:0]  stim;  // m0_req, m0_we, m1_req, m1_we
    logic [5:0]  expv;  // rmem, wmem, ack0, ack1, busy, owner
    logic [31:0] rdata0;
  } vec_t;

  vec_t vecs[11];

  function automatic vec_t mk(input logic [3:0] s, input logic [5:0] e, input logic [31:0] r);
    vec_t v;
    v.stim = s; v.expv = e; v.rdata0 = r;
    return v;
  endfunction

  // ---------------- reference model (transaction level) ----------------
  bit          m_busy, m_acc, m_owner, m_last;
  int          m_run;
  bit [1:0]    e_ack;
  logic [1:0]  p_req, p_we;
  logic [31:0] p_dfm;
  logic [DW+1:0] exp_q[$];  // {master, is_read, read data}

  task automatic model_step();
    int o;
    e_ack = 2'b00;
    if (!m_busy) begin
      if (p_req != 2'b00) begin
        m_owner = (p_req == 2'b11) ? !m_last : p_req[1];
        m_last  = m_owner;
        m_busy  = 1'b1;
        m_acc   = 1'b1;
        m_run   = 1;
      end
    end else if (m_acc) begin
      e_ack[m_owner] = 1'b1;
      exp_q.push_back({m_owner, !p_we[m_owner], p_dfm});
      m_acc = 1'b0;
    end else begin
      o = int'(m_owner);
      if (p_req[o] && (!p_req[1-o] || m_run < MAX_HOLD)) begin
        m_acc = 1'b1;
        if (m_run < MAX_HOLD) m_run++;
      end else if (p_req[1-o]) begin
        m_owner = (o == 0);
        m_last  = m_owner;
        m_run   = 1;
        m_acc   = 1'b1;
      end else begin
        m_busy = 1'b0;
      end
    end
  endtask

  task automatic new_txn(input int x);
    if (x == 0) begin
      m0_req = 1'b1; m0_we = 1'($urandom_range(0, 1));
      m0_addr = $urandom; m0_wdata = $urandom;
    end else begin
      m1_req = 1'b1; m1_we = 1'($urandom_range(0, 1));
      m1_addr = $urandom; m1_wdata = $urandom;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int  n_ack, bubbles, n0, c;
    bit  started, found;
    bit  ack_own[12];
    logic [DW+1:0] item;
    logic exp_we;

    m0_addr = 32'h0000_0800; m0_wdata = 32'h0000_1234;
    m1_addr = 32'h0000_1000; m1_wdata = 32'h0000_0005;
    d_f_mem = 32'hDEAD_BEEF;

    // Reset values, with nonzero master addresses present on the inputs.
    rst_n = 1'b0;
    m0_req = 1'b0; m1_req = 1'b0; m0_we = 1'b0; m1_we = 1'b0;
    @(posedge clk); #2;
    check("rst_m0_ack", m0_ack, 0);
    check("rst_m1_ack", m1_ack, 0);
    check("rst_m0_rdata", m0_rdata, 0);
    check("rst_m1_rdata", m1_rdata, 0);
    check("rst_wmem", wmem, 0);
    check("rst_rmem", rmem, 0);
    check("rst_mem_a", mem_a, 0);
    check("rst_d_t_mem", d_t_mem, 0);
    check("rst_owner", owner, 0);
    check("rst_busy", busy, 0);
    check("rst_state", dbg.state, ARB_IDLE);
    check("rst_last_owner", dbg.last_owner, 1);
    check("rst_hold_cnt", dbg.hold_cnt, 0);
    check("rst_ack_cyc", dbg.ack_cyc, 0);

    // Table: m0 read, m1 write, then m0 read again with idle gaps.
    vecs[0]  = mk(4'b1000, 6'b000000, 32'h0);
    vecs[1]  = mk(4'b1000, 6'b100010, 32'h0);
    vecs[2]  = mk(4'b0000, 6'b001010, 32'hDEAD_BEEF);
    vecs[3]  = mk(4'b0011, 6'b000000, 32'hDEAD_BEEF);
    vecs[4]  = mk(4'b0011, 6'b010011, 32'hDEAD_BEEF);
    vecs[5]  = mk(4'b0000, 6'b000111, 32'hDEAD_BEEF);
    vecs[6]  = mk(4'b0000, 6'b000001, 32'hDEAD_BEEF);
    vecs[7]  = mk(4'b1000, 6'b000001, 32'hDEAD_BEEF);
    vecs[8]  = mk(4'b1000, 6'b100010, 32'hDEAD_BEEF);
    vecs[9]  = mk(4'b0000, 6'b001010, 32'hCAFE_F00D);
    vecs[10] = mk(4'b0000, 6'b000000, 32'hCAFE_F00D);
    do_reset();
    for (int i = 0; i < 11; i++) begin
      @(posedge clk); #1;
      {m0_req, m0_we, m1_req, m1_we} = vecs[i].stim;
      d_f_mem = (i >= 7) ? 32'hCAFE_F00D : 32'hDEAD_BEEF;
      #1;
      check($sformatf("vec%0d_rmem", i), rmem, vecs[i].expv[5]);
      check($sformatf("vec%0d_wmem", i), wmem, vecs[i].expv[4]);
      check($sformatf("vec%0d_m0_ack", i), m0_ack, vecs[i].expv[3]);
      check($sformatf("vec%0d_m1_ack", i), m1_ack, vecs[i].expv[2]);
      check($sformatf("vec%0d_busy", i), busy, vecs[i].expv[1]);
      check($sformatf("vec%0d_owner", i), owner, vecs[i].expv[0]);
      check($sformatf("vec%0d_m0_rdata", i), m0_rdata, vecs[i].rdata0);
      check($sformatf("vec%0d_m1_rdata", i), m1_rdata, 0);
      if (vecs[i].expv[5] || vecs[i].expv[4]) begin
        check($sformatf("vec%0d_mem_a", i), mem_a,
              vecs[i].expv[0] ? 32'h0000_1000 : 32'h0000_0800);
        check($sformatf("vec%0d_d_t_mem", i), d_t_mem,
              vecs[i].expv[0] ? 32'h0000_0005 : 32'h0000_1234);
      end
    end

    // Reset during an m1 access: strobe drops at once, no ack, m0 wins after.
    @(posedge clk); #1;
    m1_req = 1'b1; m1_we = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #2;
      if (rmem) begin found = 1'b1; break; end
    end
    check("abort_access_reached", found, 1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_rmem", rmem, 0);
    check("abort_wmem", wmem, 0);
    check("abort_busy", busy, 0);
    check("abort_m1_ack_now", m1_ack, 0);
    m0_req = 1'b1; m0_we = 1'b0;
    @(posedge clk); #1;
    check("abort_m1_ack_next", m1_ack, 0);
    rst_n = 1'b1;
    @(posedge clk); #2;
    check("rearb_owner", owner, 0);
    check("rearb_rmem", rmem, 1);
    check("rearb_mem_a", mem_a, 32'h0000_0800);
    m0_req = 1'b0; m1_req = 1'b0;
    repeat (4) @(posedge clk);

    // Both masters requesting continuously from reset.
    do_reset();
    m0_req = 1'b1; m0_we = 1'b0; m1_req = 1'b1; m1_we = 1'b1;
    n_ack = 0; bubbles = 0; started = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #2;
      if (m0_ack || m1_ack) begin
        if (n_ack < 12) ack_own[n_ack] = m1_ack;
        n_ack++;
      end
      if (wmem || rmem) started = 1'b1;
      else if (started && !(m0_ack || m1_ack)) bubbles++;
    end
    check("rr_ack_count_ge12", n_ack >= 12, 1);
    for (int i = 0; i < 12; i++)
      if (i < n_ack) check($sformatf("rr_ack%0d_owner", i), ack_own[i], (i / MAX_HOLD) % 2);
    check("rr_bubbles", bubbles, 0);

    // m0 alone continuously, then m1 joins while m0's count is saturated.
    do_reset();
    m0_req = 1'b1; m0_we = 1'b1; m1_req = 1'b0; m1_we = 1'b0;
    n0 = 0; c = 0;
    while (n0 < 10 && c < 40) begin
      @(posedge clk); #2;
      if (m0_ack) n0++;
      c++;
    end
    check("solo_m0_acks", n0, 10);
    check("solo_hold_saturated", dbg.hold_cnt, MAX_HOLD);
    m1_req = 1'b1; m1_we = 1'b1;
    n0 = 0; found = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #2;
      if (m0_ack) n0++;
      if (wmem && owner) begin found = 1'b1; break; end
    end
    check("starve_m1_granted", found, 1);
    check("starve_m0_within_bound", n0 <= MAX_HOLD, 1);
    check("switch_hold_rearmed", dbg.hold_cnt, 1);
    // Both drop req inside m1's access cycle: the access still completes.
    m0_req = 1'b0; m1_req = 1'b0;
    @(posedge clk); #2;
    check("drop_req_m1_ack", m1_ack, 1);
    check("drop_req_m0_ack", m0_ack, 0);
    repeat (3) @(posedge clk);

    // Randomized traffic against the reference model.
    do_reset();
    m_busy = 1'b0; m_acc = 1'b0; m_owner = 1'b0; m_last = 1'b1; m_run = 0;
    exp_q.delete();
    p_req = 2'b00; p_we = 2'b00; p_dfm = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk);
      model_step();
      #1;
      check("rnd_m0_ack", m0_ack, e_ack[0]);
      check("rnd_m1_ack", m1_ack, e_ack[1]);
      check("rnd_owner", owner, m_owner);
      check("rnd_busy", busy, m_busy);
      if (e_ack != 2'b00) begin
        if (exp_q.size() == 0) begin
          check("rnd_scoreboard_empty", 1, 0);
        end else begin
          item = exp_q.pop_front();
          if (item[DW])
            check("rnd_rdata", item[DW+1] ? m1_rdata : m0_rdata, item[DW-1:0]);
        end
      end
      // Masters respond to the expected ack or start new work.
      if (e_ack[0]) begin
        if ($urandom_range(0, 1) == 1) new_txn(0); else m0_req = 1'b0;
      end else if (!m0_req && $urandom_range(0, 3) == 0) new_txn(0);
      if (e_ack[1]) begin
        if ($urandom_range(0, 1) == 1) new_txn(1); else m1_req = 1'b0;
      end else if (!m1_req && $urandom_range(0, 3) == 0) new_txn(1);
      d_f_mem = $urandom;
      #1;
      exp_we = m_owner ? m1_we : m0_we;
      check("rnd_wmem", wmem, m_acc && exp_we);
      check("rnd_rmem", rmem, m_acc && !exp_we);
      if (m_acc) begin
        check("rnd_mem_a", mem_a, m_owner ? m1_addr : m0_addr);
        if (exp_we) check("rnd_d_t_mem", d_t_mem, m_owner ? m1_wdata : m0_wdata);
      end
      p_req = {m1_req, m0_req};
      p_we  = {m1_we, m0_we};
      p_dfm = d_f_mem;
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
